// File: rtl/gerador_tentativa.sv
// Code-entry front end: conditions the enter button, snapshots the switches,
// strobes the comparator and tracks remaining attempts until win or lock.
`timescale 1ns/1ps
module gerador_tentativa #(
    parameter int LARGURA         = 7,
    parameter int MAX_TENTATIVAS  = 3,
    parameter int DEBOUNCE_CICLOS = 4,
    parameter int PULSO_ENTER     = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LARGURA-1:0] chaves,
    input  logic               botao_enter,
    input  logic               sinalvitoria,
    output logic [LARGURA-1:0] tentativa,
    output logic               enter,
    output logic [3:0]         tentativas_restantes,
    output logic               ocupado,
    output logic               acertou,
    output logic               bloqueado
);

    localparam int DW = $clog2(DEBOUNCE_CICLOS + 1);
    localparam int PW = $clog2(PULSO_ENTER + 1);

    typedef enum logic [2:0] {
        OCIOSO,
        CAPTURA,
        ENVIA,
        AGUARDA,
        ACERTOU,
        BLOQUEADO
    } estado_t;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          deb_q, deb_d;
    logic          deb_ant_q, deb_ant_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          press_q, press_d;

    estado_t       estado_q, estado_d;
    logic [PW-1:0] pulso_cnt_q, pulso_cnt_d;

    logic [LARGURA-1:0] tentativa_q, tentativa_d;
    logic               enter_q, enter_d;
    logic [3:0]         restantes_q, restantes_d;
    logic               ocupado_q, ocupado_d;
    logic               acertou_q, acertou_d;
    logic               bloqueado_q, bloqueado_d;

    logic captura_ok;
    logic ultima;

    // Button conditioning: a level change needs DEBOUNCE_CICLOS differing cycles
    always_comb begin
        sync1_d   = botao_enter;
        sync2_d   = sync1_q;
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DW'(DEBOUNCE_CICLOS - 1)) begin
                deb_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
        deb_ant_d = deb_q;
        press_d   = deb_q & ~deb_ant_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_q     <= 1'b0;
            deb_ant_q <= 1'b0;
            deb_cnt_q <= '0;
            press_q   <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            deb_ant_q <= deb_ant_d;
            deb_cnt_q <= deb_cnt_d;
            press_q   <= press_d;
        end
    end

    assign captura_ok = (estado_q == OCIOSO) && press_q;
    assign ultima     = (restantes_q <= 4'd1);

    // FSM state register together with the registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q    <= OCIOSO;
            pulso_cnt_q <= '0;
            tentativa_q <= '0;
            enter_q     <= 1'b0;
            restantes_q <= 4'(MAX_TENTATIVAS);
            ocupado_q   <= 1'b0;
            acertou_q   <= 1'b0;
            bloqueado_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            pulso_cnt_q <= pulso_cnt_d;
            tentativa_q <= tentativa_d;
            enter_q     <= enter_d;
            restantes_q <= restantes_d;
            ocupado_q   <= ocupado_d;
            acertou_q   <= acertou_d;
            bloqueado_q <= bloqueado_d;
        end
    end

    always_comb begin
        estado_d    = estado_q;
        pulso_cnt_d = '0;
        unique case (estado_q)
            OCIOSO: begin
                if (press_q) begin
                    estado_d = CAPTURA;
                end
            end
            CAPTURA: begin
                estado_d = ENVIA;
            end
            ENVIA: begin
                if (pulso_cnt_q == PW'(PULSO_ENTER - 1)) begin
                    estado_d = AGUARDA;
                end else begin
                    pulso_cnt_d = pulso_cnt_q + 1'b1;
                end
            end
            AGUARDA: begin
                if (sinalvitoria) begin
                    estado_d = ACERTOU;
                end else if (ultima) begin
                    estado_d = BLOQUEADO;
                end else begin
                    estado_d = OCIOSO;
                end
            end
            ACERTOU: begin
                estado_d = ACERTOU;
            end
            BLOQUEADO: begin
                estado_d = BLOQUEADO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // Outputs are registered from the next state so enter never glitches
    always_comb begin
        tentativa_d = tentativa_q;
        ocupado_d   = ocupado_q;
        restantes_d = restantes_q;
        acertou_d   = acertou_q;
        bloqueado_d = bloqueado_q;
        enter_d     = (estado_d == ENVIA);
        if (captura_ok) begin
            tentativa_d = chaves;
            ocupado_d   = 1'b1;
        end
        if (estado_q == AGUARDA) begin
            ocupado_d = 1'b0;
            if (sinalvitoria) begin
                acertou_d = 1'b1;
            end else begin
                if (restantes_q != 4'd0) begin
                    restantes_d = restantes_q - 4'd1;
                end
                if (ultima) begin
                    bloqueado_d = 1'b1;
                end
            end
        end
    end

    assign tentativa            = tentativa_q;
    assign enter                = enter_q;
    assign tentativas_restantes = restantes_q;
    assign ocupado              = ocupado_q;
    assign acertou              = acertou_q;
    assign bloqueado            = bloqueado_q;

endmodule

// File: tb/tb_gerador_tentativa.sv
// Bench for gerador_tentativa with a behavioural comparator (senha = 42)
// and a scoreboard of expected submitted codes.
`timescale 1ns/1ps
module tb_gerador_tentativa;

    localparam logic [6:0] SENHA = 7'd42;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] chaves = '0;
    logic       botao = 1'b0;
    logic       sinal;
    logic [6:0] tentativa;
    logic       enter;
    logic [3:0] restantes;
    logic       ocupado;
    logic       acertou;
    logic       bloqueado;

    int checks = 0;
    int errors = 0;

    logic [6:0] exp_q[$];

    int         n_enter = 0;
    int         run_len = 0;
    int         last_len = 0;
    logic [6:0] tent_at_enter = '0;
    logic       mon_prev = 1'b0;
    logic       enter_d1;

    always #5 clk = ~clk;

    gerador_tentativa #(
        .LARGURA(7),
        .MAX_TENTATIVAS(3),
        .DEBOUNCE_CICLOS(4),
        .PULSO_ENTER(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .chaves(chaves),
        .botao_enter(botao),
        .sinalvitoria(sinal),
        .tentativa(tentativa),
        .enter(enter),
        .tentativas_restantes(restantes),
        .ocupado(ocupado),
        .acertou(acertou),
        .bloqueado(bloqueado)
    );

    // Comparator: latches its verdict on the rising edge of enter
    always @(posedge clk) begin
        if (reset) begin
            sinal    <= 1'b0;
            enter_d1 <= 1'b0;
        end else begin
            enter_d1 <= enter;
            if (enter && !enter_d1) begin
                sinal <= (tentativa == SENHA);
            end
        end
    end

    always @(negedge clk) begin
        if (enter && !mon_prev) begin
            n_enter       = n_enter + 1;
            run_len       = 1;
            tent_at_enter = tentativa;
        end else if (enter) begin
            run_len = run_len + 1;
        end
        if (!enter && mon_prev) begin
            last_len = run_len;
        end
        mon_prev = enter;
    end

    task automatic apply_reset();
        reset = 1'b1;
        botao = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic submit(input logic [6:0] val, output int pulses,
                          output logic [6:0] seen, output int len);
        int n0;
        n0 = n_enter;
        chaves = val;
        exp_q.push_back(val);
        botao = 1'b1;
        repeat (10) @(posedge clk);
        #1 botao = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        pulses = n_enter - n0;
        seen   = tent_at_enter;
        len    = last_len;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++; if (tentativa !== 7'd0) begin errors++; $display("FAIL rst_tentativa got %0d want 0", tentativa); end
        checks++; if (enter !== 1'b0) begin errors++; $display("FAIL rst_enter got %0b want 0", enter); end
        checks++; if (restantes !== 4'd3) begin errors++; $display("FAIL rst_restantes got %0d want 3", restantes); end
        checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL rst_ocupado got %0b want 0", ocupado); end
        checks++; if (acertou !== 1'b0) begin errors++; $display("FAIL rst_acertou got %0b want 0", acertou); end
        checks++; if (bloqueado !== 1'b0) begin errors++; $display("FAIL rst_bloqueado got %0b want 0", bloqueado); end
    endtask

    task automatic test_latency_win();
        int t_at, e_at, o_at, n0;
        logic [6:0] exp;
        t_at = -1; e_at = -1; o_at = -1;
        apply_reset();
        n0 = n_enter;
        chaves = SENHA;
        exp_q.push_back(SENHA);
        botao = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (t_at < 0 && tentativa == SENHA) t_at = k;
            if (e_at < 0 && enter) e_at = k;
            if (o_at < 0 && ocupado) o_at = k;
        end
        botao = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++; if (t_at != 7) begin errors++; $display("FAIL lat_tentativa edge got %0d want 7", t_at); end
        checks++; if (o_at != 7) begin errors++; $display("FAIL lat_ocupado edge got %0d want 7", o_at); end
        checks++; if (e_at != 8) begin errors++; $display("FAIL lat_enter edge got %0d want 8", e_at); end
        checks++; if (n_enter - n0 != 1) begin errors++; $display("FAIL win_pulses got %0d want 1", n_enter - n0); end
        exp = exp_q.pop_front();
        checks++; if (tent_at_enter !== exp) begin errors++; $display("FAIL win_code got %0d want %0d", tent_at_enter, exp); end
        checks++; if (last_len != 2) begin errors++; $display("FAIL win_len got %0d want 2", last_len); end
        checks++; if (acertou !== 1'b1) begin errors++; $display("FAIL win_acertou got %0b want 1", acertou); end
        checks++; if (bloqueado !== 1'b0) begin errors++; $display("FAIL win_bloqueado got %0b want 0", bloqueado); end
        checks++; if (restantes !== 4'd3) begin errors++; $display("FAIL win_restantes got %0d want 3", restantes); end
        checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL win_ocupado got %0b want 0", ocupado); end
    endtask

    task automatic test_lockout();
        logic [6:0] codes [3];
        logic [3:0] rest_exp [3];
        int pulses, len, n0;
        logic [6:0] seen, exp;
        codes = '{7'd5, 7'd6, 7'd7};
        rest_exp = '{4'd2, 4'd1, 4'd0};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            submit(codes[i], pulses, seen, len);
            exp = exp_q.pop_front();
            checks++; if (pulses != 1) begin errors++; $display("FAIL lock_pulses[%0d] got %0d want 1", i, pulses); end
            checks++; if (seen !== exp) begin errors++; $display("FAIL lock_code[%0d] got %0d want %0d", i, seen, exp); end
            checks++; if (len != 2) begin errors++; $display("FAIL lock_len[%0d] got %0d want 2", i, len); end
            checks++; if (restantes !== rest_exp[i]) begin errors++; $display("FAIL lock_restantes[%0d] got %0d want %0d", i, restantes, rest_exp[i]); end
            checks++; if (bloqueado !== (i == 2)) begin errors++; $display("FAIL lock_bloqueado[%0d] got %0b want %0b", i, bloqueado, (i == 2)); end
        end
        checks++; if (acertou !== 1'b0) begin errors++; $display("FAIL lock_acertou got %0b want 0", acertou); end
        n0 = n_enter;
        chaves = SENHA;
        botao = 1'b1;
        repeat (10) @(posedge clk);
        #1 botao = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++; if (n_enter != n0) begin errors++; $display("FAIL lock_4th_pulses got %0d want 0", n_enter - n0); end
        checks++; if (restantes !== 4'd0) begin errors++; $display("FAIL lock_4th_restantes got %0d want 0", restantes); end
        checks++; if (acertou !== 1'b0) begin errors++; $display("FAIL lock_4th_acertou got %0b want 0", acertou); end
    endtask

    task automatic test_glitch();
        int n0;
        apply_reset();
        n0 = n_enter;
        chaves = 7'd99;
        for (int r = 0; r < 5; r++) begin
            botao = 1'b1;
            repeat (3) @(posedge clk);
            #1 botao = 1'b0;
            @(posedge clk);
            #1;
        end
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++; if (n_enter != n0) begin errors++; $display("FAIL glitch_pulses got %0d want 0", n_enter - n0); end
        checks++; if (enter !== 1'b0) begin errors++; $display("FAIL glitch_enter got %0b want 0", enter); end
        checks++; if (tentativa !== 7'd0) begin errors++; $display("FAIL glitch_tentativa got %0d want 0", tentativa); end
        checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL glitch_ocupado got %0b want 0", ocupado); end
    endtask

    task automatic test_press_during_envia();
        int n0;
        logic [6:0] exp;
        apply_reset();
        n0 = n_enter;
        chaves = 7'd9;
        exp_q.push_back(7'd9);
        botao = 1'b1;
        repeat (9) @(posedge clk);
        #1 chaves = SENHA;
        botao = 1'b0;
        @(negedge clk);
        checks++; if (enter !== 1'b1) begin errors++; $display("FAIL envia_enter got %0b want 1", enter); end
        checks++; if (tentativa !== 7'd9) begin errors++; $display("FAIL envia_hold got %0d want 9", tentativa); end
        @(posedge clk);
        #1 botao = 1'b1;
        repeat (8) @(posedge clk);
        #1 botao = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        exp = exp_q.pop_front();
        checks++; if (n_enter - n0 != 1) begin errors++; $display("FAIL envia_pulses got %0d want 1", n_enter - n0); end
        checks++; if (tent_at_enter !== exp) begin errors++; $display("FAIL envia_code got %0d want %0d", tent_at_enter, exp); end
        checks++; if (tentativa !== 7'd9) begin errors++; $display("FAIL envia_final got %0d want 9", tentativa); end
        checks++; if (restantes !== 4'd2) begin errors++; $display("FAIL envia_restantes got %0d want 2", restantes); end
    endtask

    task automatic test_reset_in_envia();
        int pulses, len;
        logic [6:0] seen, exp;
        apply_reset();
        chaves = 7'd5;
        botao = 1'b1;
        repeat (9) @(posedge clk);
        @(negedge clk);
        checks++; if (enter !== 1'b1) begin errors++; $display("FAIL rstenv_pre_enter got %0b want 1", enter); end
        reset = 1'b1;
        botao = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (enter !== 1'b0) begin errors++; $display("FAIL rstenv_enter got %0b want 0", enter); end
        checks++; if (tentativa !== 7'd0) begin errors++; $display("FAIL rstenv_tentativa got %0d want 0", tentativa); end
        checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL rstenv_ocupado got %0b want 0", ocupado); end
        checks++; if (restantes !== 4'd3) begin errors++; $display("FAIL rstenv_restantes got %0d want 3", restantes); end
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        submit(SENHA, pulses, seen, len);
        exp = exp_q.pop_front();
        checks++; if (pulses != 1) begin errors++; $display("FAIL rstenv_pulses got %0d want 1", pulses); end
        checks++; if (seen !== exp) begin errors++; $display("FAIL rstenv_code got %0d want %0d", seen, exp); end
        checks++; if (acertou !== 1'b1) begin errors++; $display("FAIL rstenv_acertou got %0b want 1", acertou); end
    endtask

    task automatic test_reset_vs_press();
        int n0;
        apply_reset();
        n0 = n_enter;
        chaves = SENHA;
        botao = 1'b1;
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        botao = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++; if (tentativa !== 7'd0) begin errors++; $display("FAIL rstpress_tentativa got %0d want 0", tentativa); end
        checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL rstpress_ocupado got %0b want 0", ocupado); end
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++; if (n_enter != n0) begin errors++; $display("FAIL rstpress_pulses got %0d want 0", n_enter - n0); end
    endtask

    task automatic test_last_attempt_win();
        logic [6:0] codes [3];
        int pulses, len;
        logic [6:0] seen, exp;
        codes = '{7'd5, 7'd6, SENHA};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            submit(codes[i], pulses, seen, len);
            exp = exp_q.pop_front();
            checks++; if (seen !== exp || pulses != 1) begin errors++; $display("FAIL last_code[%0d] got %0d x%0d want %0d x1", i, seen, pulses, exp); end
        end
        checks++; if (acertou !== 1'b1) begin errors++; $display("FAIL last_acertou got %0b want 1", acertou); end
        checks++; if (restantes !== 4'd1) begin errors++; $display("FAIL last_restantes got %0d want 1", restantes); end
        checks++; if (bloqueado !== 1'b0) begin errors++; $display("FAIL last_bloqueado got %0b want 0", bloqueado); end
    endtask

    initial begin
        test_reset();
        test_latency_win();
        test_lockout();
        test_glitch();
        test_press_during_envia();
        test_reset_in_envia();
        test_reset_vs_press();
        test_last_attempt_win();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
